// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver, LSB first, 16x oversampling with mid-bit sampling.
//
// Converts the asynchronous serial line into bytes presented with a
// valid/ready handshake. Rejects false starts (start bit not low at its
// midpoint), flags framing errors (stop bit low), and flags overruns (a new
// byte completes while the previous one is still unaccepted).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   rx_serial    asynchronous serial line, idle high
//   data_out     received byte, stable while data_valid=1
//   data_valid   byte available, held until accepted
//   data_ready   consumer accepts on data_valid && data_ready at a rising clk
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun_err  one-cycle pulse: byte completed while data_valid still high
//   busy         high in any state except IDLE
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge (needs a prior high)
// START     | counting 8 ticks to the middle of the start bit
// DATA      | sampling 8 data bits, one every 16 ticks, LSB first
// STOP      | counting 16 ticks to the middle of the stop bit
// WAIT_IDLE | framing error seen, waiting for the line to return high

module uart_rx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    localparam int DIV_RAW = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          rx_meta, rxs;
    logic [1:0]    sync_fill;
    logic          armed;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    tcnt, tcnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift_reg, shift_n;
    logic          byte_done;
    logic          frame_det;

    // Two-flop synchronizer, both stages reset high (idle line).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rxs     <= rx_meta;
        end
    end

    // The synchronizer's reset value is not a real line sample, so the
    // receiver only arms once rxs carries a genuine sample and that sample
    // is high. A line held low through reset release cannot fake a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_fill <= 2'd0;
            armed     <= 1'b0;
        end else begin
            if (sync_fill != 2'd2)
                sync_fill <= sync_fill + 2'd1;
            if (sync_fill == 2'd2 && rxs)
                armed <= 1'b1;
        end
    end

    // Oversampling tick generator, parked at 0 in IDLE so its phase is
    // aligned to the detected start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (state == IDLE || div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DW'(1);
    end

    assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= 4'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        tcnt_n    = tcnt;
        bit_idx_n = bit_idx;
        shift_n   = shift_reg;
        byte_done = 1'b0;
        frame_det = 1'b0;
        case (state)
            IDLE: begin
                tcnt_n    = 4'd0;
                bit_idx_n = 3'd0;
                if (armed && !rxs)
                    state_n = START;
            end
            START: begin
                if (tick) begin
                    if (tcnt == 4'd7) begin
                        tcnt_n    = 4'd0;
                        bit_idx_n = 3'd0;
                        state_n   = rxs ? IDLE : DATA;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == 4'd15) begin
                        tcnt_n           = 4'd0;
                        shift_n[bit_idx] = rxs;
                        if (bit_idx == 3'd7)
                            state_n = STOP;
                        else
                            bit_idx_n = bit_idx + 3'd1;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tcnt == 4'd15) begin
                        tcnt_n = 4'd0;
                        if (rxs) begin
                            byte_done = 1'b1;
                            state_n   = IDLE;
                        end else begin
                            frame_det = 1'b1;
                            state_n   = WAIT_IDLE;
                        end
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output holding register. A byte completing on the same cycle the
    // previous one is accepted replaces it without an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_det;
            overrun_err <= 1'b0;
            if (byte_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift_reg;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx at DIV=1 (100 ns clk, 1600 ns bit).

module tb_uart_rx;

    localparam int BIT_NS = 1600;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic       data_ready = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    uart_rx #(
        .CLK_FREQ_HZ(10_000_000),
        .BAUD_RATE  (625_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb[$];
    int n_valid = 0, n_frame = 0, n_ovr = 0;
    int v0, f0, o0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the rising edge where
    // the DUT updates and the handshake completes.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (data_valid)  n_valid++;
        if (frame_err)   n_frame++;
        if (overrun_err) n_ovr++;
        if (data_valid && data_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_b = sb.pop_front();
                check("rx_byte", 32'(data_out), 32'(exp_b));
            end
        end
    end

    task automatic snap();
        v0 = n_valid;
        f0 = n_frame;
        o0 = n_ovr;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx_serial = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            #(BIT_NS);
        end
        rx_serial = stop_lvl;
        #(BIT_NS);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    initial begin
        // reset state
        #200;
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        #100 rst = 1'b0;
        #1000;

        // 1: single byte, data_ready high
        snap();
        sb.push_back(8'h41);
        send_byte(8'h41);
        check("t1_busy", 32'(busy), 32'd0);
        #(BIT_NS);
        check("t1_valid_cycles", 32'(n_valid - v0), 32'd1);
        check("t1_ferr", 32'(n_frame - f0), 32'd0);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: false start
        snap();
        rx_serial = 1'b0;
        #300;
        check("t2_busy_hi", 32'(busy), 32'd1);
        rx_serial = 1'b1;
        #900;
        check("t2_busy_lo", 32'(busy), 32'd0);
        #(BIT_NS);
        check("t2_valid", 32'(n_valid - v0), 32'd0);
        check("t2_ferr", 32'(n_frame - f0), 32'd0);

        // 3: framing error with stop held low for 3 bits, then a good byte
        snap();
        rx_serial = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_serial = (8'hA5 >> i) & 1'b1;
            #(BIT_NS);
        end
        rx_serial = 1'b0;
        #(3 * BIT_NS);
        rx_serial = 1'b1;
        #(BIT_NS);
        check("t3_ferr", 32'(n_frame - f0), 32'd1);
        check("t3_valid", 32'(n_valid - v0), 32'd0);
        check("t3_ovr", 32'(n_ovr - o0), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        snap();
        sb.push_back(8'h3C);
        send_byte(8'h3C);
        #(BIT_NS);
        check("t3b_valid_cycles", 32'(n_valid - v0), 32'd1);
        check("t3b_data", 32'(data_out), 32'h3C);
        check("t3b_ferr", 32'(n_frame - f0), 32'd0);

        // 4: overrun while data_ready low
        data_ready = 1'b0;
        snap();
        sb.push_back(8'h11);
        send_byte(8'h11);
        send_byte(8'h22);
        #(BIT_NS);
        check("t4_valid", 32'(data_valid), 32'd1);
        check("t4_data", 32'(data_out), 32'h11);
        check("t4_ovr", 32'(n_ovr - o0), 32'd1);
        check("t4_ferr", 32'(n_frame - f0), 32'd0);
        @(posedge clk);
        #10 data_ready = 1'b1;
        @(negedge clk);
        #200;
        check("t4_valid_drop", 32'(data_valid), 32'd0);
        check("t4_data_keep", 32'(data_out), 32'h11);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: reset mid-frame during data bit 3 of 0xFF
        snap();
        rx_serial = 1'b0;
        #(BIT_NS);
        rx_serial = 1'b1;
        #(3 * BIT_NS + BIT_NS / 2);
        rst = 1'b1;
        #100;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(data_valid), 32'd0);
        check("t5_data", 32'(data_out), 32'd0);
        check("t5_ferr", 32'(frame_err), 32'd0);
        check("t5_ovr", 32'(overrun_err), 32'd0);
        #100 rst = 1'b0;
        #(BIT_NS / 2 + 5 * BIT_NS);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_no_valid", 32'(n_valid - v0), 32'd0);
        snap();
        sb.push_back(8'h7E);
        send_byte(8'h7E);
        #(BIT_NS);
        check("t5b_valid_cycles", 32'(n_valid - v0), 32'd1);
        check("t5b_data", 32'(data_out), 32'h7E);

        // 6: "Hi" with half-bit gaps, then 0x00/0xFF back-to-back
        snap();
        sb.push_back(8'h48);
        sb.push_back(8'h69);
        sb.push_back(8'h00);
        sb.push_back(8'hFF);
        send_byte(8'h48);
        #(BIT_NS / 2);
        send_byte(8'h69);
        #(BIT_NS / 2);
        send_byte(8'h00);
        send_byte(8'hFF);
        #(BIT_NS);
        check("t6_valid_cycles", 32'(n_valid - v0), 32'd4);
        check("t6_ferr", 32'(n_frame - f0), 32'd0);
        check("t6_ovr", 32'(n_ovr - o0), 32'd0);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        check("t6_data", 32'(data_out), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
